// File: rtl/demux_dist.sv
// ============================================================================
// Module      : demux_dist
// Description : 1-to-N lane demultiplexer; each lane holds one word until acked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_dist #(
  parameter int WIDTH = 2,
  parameter int SEL_W = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SEL_W-1:0]               sel,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [(2**SEL_W)*WIDTH-1:0]    out_data,
  output logic [(2**SEL_W)-1:0]          out_valid,
  input  logic [(2**SEL_W)-1:0]          out_ack,
  output logic [SEL_W:0]                 occ,
  output logic [7:0]                     xfer_cnt
);

  localparam int N = 2**SEL_W;

  logic           accept;
  logic [N-1:0]   load;
  logic [SEL_W:0] occ_inc;
  logic [SEL_W:0] occ_dec;

  // A full lane being acked this cycle is free to take the new word.
  assign in_ready = ~out_valid[sel] | out_ack[sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) load[sel] = 1'b1;
  end

  // Occupancy delta: a reload of an acked lane is net zero, so it is
  // excluded from both the increment and the decrement.
  assign occ_inc = (SEL_W+1)'(accept & ~out_valid[sel]);

  always_comb begin
    occ_dec = '0;
    for (int k = 0; k < N; k++) begin
      occ_dec = occ_dec + (SEL_W+1)'(out_valid[k] & out_ack[k] & ~load[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      occ       <= '0;
      xfer_cnt  <= '0;
    end else begin
      out_valid <= (out_valid & ~out_ack) | load;
      occ       <= occ + occ_inc - occ_dec;
      xfer_cnt  <= xfer_cnt + 8'(accept);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) out_data[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_demux_dist.sv
// Self-checking bench for demux_dist against a lane-array reference model.
`default_nettype none

module tb_demux_dist;

  localparam int WIDTH = 2;
  localparam int SEL_W = 5;
  localparam int N     = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [SEL_W-1:0]  sel;
  logic [WIDTH-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ack;
  logic [SEL_W:0]    occ;
  logic [7:0]        xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one entry per lane plus an accept counter.
  bit       m_valid [N];
  bit [1:0] m_data  [N];
  int       m_cnt;

  demux_dist #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .occ(occ), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 0;
      m_data[k]  = 0;
    end
    m_cnt = 0;
  endtask

  function automatic bit model_ready();
    return !m_valid[sel] || out_ack[sel];
  endfunction

  task automatic model_edge();
    bit rdy;
    rdy = model_ready();
    for (int k = 0; k < N; k++) if (out_ack[k]) m_valid[k] = 0;
    if (in_valid && rdy) begin
      m_valid[sel] = 1;
      m_data[sel]  = in_data;
      m_cnt        = (m_cnt + 1) % 256;
    end
  endtask

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_valid[k];
    return v;
  endfunction

  function automatic logic [N*WIDTH-1:0] exp_data();
    logic [N*WIDTH-1:0] d;
    for (int k = 0; k < N; k++) d[k*WIDTH +: WIDTH] = m_data[k];
    return d;
  endfunction

  function automatic int exp_occ();
    int c = 0;
    for (int k = 0; k < N; k++) c += m_valid[k];
    return c;
  endfunction

  task automatic tick();
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0;
    sel      = '0;
    in_data  = '0;
    out_ack  = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    in_valid = 1; sel = 5'd3; in_data = 2'b11;
    tick();
    n_checks++;
    if (out_valid !== '0) begin n_fail++; $display("FAIL reset_valid got %h want 0", out_valid); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_checks++;
    if (occ !== '0 || xfer_cnt !== '0) begin n_fail++; $display("FAIL reset_counts occ=%0d cnt=%0d want 0/0", occ, xfer_cnt); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    @(negedge clk);
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_valid = 1; sel = 5'd5; in_data = 2'b10;
    tick();
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== 32'h0000_0020) begin n_fail++; $display("FAIL basic_valid got %h want 00000020", out_valid); end
    n_checks++;
    if (out_data[11:10] !== 2'b10) begin n_fail++; $display("FAIL basic_data got %b want 10", out_data[11:10]); end
    n_checks++;
    if (occ !== 6'd1 || xfer_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_counts occ=%0d cnt=%0d want 1/1", occ, xfer_cnt); end
  endtask

  task automatic test_full_block();
    @(negedge clk);
    in_valid = 1; sel = 5'd5; in_data = 2'b01; out_ack = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL block_ready got %b want 0", in_ready); end
    tick();
    n_checks++;
    if (out_data[11:10] !== 2'b10 || xfer_cnt !== 8'd1) begin n_fail++; $display("FAIL block_hold data=%b cnt=%0d want 10/1", out_data[11:10], xfer_cnt); end
  endtask

  task automatic test_ack_reload();
    @(negedge clk);
    in_valid = 1; sel = 5'd5; in_data = 2'b01; out_ack = 32'h0000_0020;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reload_ready got %b want 1", in_ready); end
    tick();
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid[5] !== 1'b1 || out_data[11:10] !== 2'b01) begin n_fail++; $display("FAIL reload_lane v=%b d=%b want 1/01", out_valid[5], out_data[11:10]); end
    n_checks++;
    if (occ !== 6'd1 || xfer_cnt !== 8'd2) begin n_fail++; $display("FAIL reload_counts occ=%0d cnt=%0d want 1/2", occ, xfer_cnt); end
  endtask

  task automatic test_all_lanes();
    @(negedge clk);
    idle_inputs();
    out_ack = '1;
    tick();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      idle_inputs();
      in_valid = 1; sel = 5'(k); in_data = 2'($urandom);
      tick();
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (occ !== 6'd32 || out_valid !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL all_full occ=%0d v=%h want 32/ffffffff", occ, out_valid); end
    n_checks++;
    if (out_data !== exp_data()) begin n_fail++; $display("FAIL all_data got %h want %h", out_data, exp_data()); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL all_ready got %b want 0", in_ready); end
    out_ack = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== '0 || occ !== '0) begin n_fail++; $display("FAIL all_drain v=%h occ=%0d want 0/0", out_valid, occ); end
    n_checks++;
    if (out_data !== exp_data()) begin n_fail++; $display("FAIL drain_data got %h want %h", out_data, exp_data()); end
  endtask

  task automatic test_wrap();
    logic [N-1:0]       v_before;
    logic [N*WIDTH-1:0] d_before;
    logic [SEL_W:0]     o_before;
    @(negedge clk);
    rst = 1;
    idle_inputs();
    tick();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      in_valid = 1;
      sel      = (i == 255) ? 5'd2 : 5'($urandom);
      in_data  = 2'($urandom);
      out_ack  = '1;
      tick();
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (xfer_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt got %0d want 0", xfer_cnt); end
    n_checks++;
    if (out_valid !== exp_valid() || occ !== 6'(exp_occ())) begin n_fail++; $display("FAIL wrap_state v=%h occ=%0d want %h/%0d", out_valid, occ, exp_valid(), exp_occ()); end
    v_before = out_valid; d_before = out_data; o_before = occ;
    out_ack = 32'h0000_0080;
    tick();
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== v_before || out_data !== d_before || occ !== o_before || xfer_cnt !== 8'd0)
    begin n_fail++; $display("FAIL empty_ack v=%h occ=%0d cnt=%0d want %h/%0d/0", out_valid, occ, xfer_cnt, v_before, o_before); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      sel      = 5'($urandom_range(0, 7));
      in_data  = 2'($urandom);
      out_ack  = $urandom & $urandom & $urandom;
      #1;
      n_checks++;
      if (in_ready !== model_ready()) begin n_fail++; $display("FAIL rand_ready i=%0d got %b want %b", i, in_ready, model_ready()); end
      tick();
      n_checks++;
      if (out_valid !== exp_valid() || out_data !== exp_data() || occ !== 6'(exp_occ()) || xfer_cnt !== 8'(m_cnt))
      begin n_fail++; $display("FAIL rand_state i=%0d v=%h occ=%0d cnt=%0d want v=%h occ=%0d cnt=%0d", i, out_valid, occ, xfer_cnt, exp_valid(), exp_occ(), m_cnt); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ack = '1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      idle_inputs();
      in_valid = 1; sel = 5'(k); in_data = 2'b11;
      tick();
    end
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (occ !== 6'd3) begin n_fail++; $display("FAIL async_pre occ=%0d want 3", occ); end
    #2;
    rst = 1;
    #1;
    n_checks++;
    if (out_valid !== '0 || occ !== '0 || xfer_cnt !== '0 || out_data !== '0)
    begin n_fail++; $display("FAIL async_clear v=%h occ=%0d cnt=%0d want 0/0/0", out_valid, occ, xfer_cnt); end
    model_reset();
    @(negedge clk);
    rst = 0;
    in_valid = 1; sel = 5'd9; in_data = 2'b01;
    tick();
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (out_valid !== 32'h0000_0200 || occ !== 6'd1 || xfer_cnt !== 8'd1)
    begin n_fail++; $display("FAIL post_reset v=%h occ=%0d cnt=%0d want 00000200/1/1", out_valid, occ, xfer_cnt); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_full_block();
    test_ack_reload();
    test_all_lanes();
    test_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_dist.md
DEMUX_DIST -- requirements
Module: demux_dist

Interface
REQ-001 SHALL have parameter WIDTH, default 2: lane data width in bits.
REQ-002 SHALL have parameter SEL_W, default 5: select width; lane count N = 2**SEL_W (32).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sel  input  SEL_W  destination lane index for the current input word.
REQ-006 SHALL have port in_data  input  WIDTH  word to deliver.
REQ-007 SHALL have port in_valid  input  1  producer offers in_data/sel this cycle.
REQ-008 SHALL have port in_ready  output  1  block can accept this cycle (combinational).
REQ-009 SHALL have port out_data  output  N*WIDTH  lane k held word at bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-010 SHALL have port out_valid  output  N  bit k = lane k holds an unconsumed word.
REQ-011 SHALL have port out_ack  input  N  bit k = consumer of lane k takes its word this cycle.
REQ-012 SHALL have port occ  output  SEL_W+1  number of lanes with out_valid set (0..N).
REQ-013 SHALL have port xfer_cnt  output  8  count of accepted input words, modulo 256.

Function
REQ-014 SHALL drive in_ready = !out_valid[sel] | out_ack[sel]; a full lane freed by an ack in the same cycle counts as free.
REQ-015 SHALL accept a word when in_valid & in_ready are both 1 at a rising edge; nothing else constitutes a transfer.
REQ-016 SHALL, on accept, load in_data into lane sel and set out_valid[sel] at that edge; latency 1 cycle input-to-output.
REQ-017 SHALL, for lane k with out_valid[k]=1 and out_ack[k]=1 and no accept to k, clear out_valid[k] at that edge.
REQ-018 SHALL, on simultaneous ack of lane k and accept to lane k, keep out_valid[k]=1 and load the new word (no bubble).
REQ-019 SHALL ignore out_ack[k] when out_valid[k]=0; no state changes.
REQ-020 SHALL hold lane k data stable while out_valid[k]=1 and not overwritten per REQ-018; after clear, data retains last value.
REQ-021 SHALL never overwrite a lane with out_valid=1 absent a same-cycle ack; in_valid with in_ready=0 changes no state (producer must hold).
REQ-022 SHALL process acks on all lanes independently in one cycle; any subset of out_ack may be high together.
REQ-023 SHALL register occ as a count equal to popcount(out_valid) after every edge: +1 on accept to empty lane, -1 per qualifying ack, net across simultaneous events.
REQ-024 SHALL increment xfer_cnt by 1 per accept, wrapping 255 -> 0.
REQ-025 SHALL treat sel/in_data as don't-care when in_valid=0.

Reset
REQ-026 SHALL, while rst=1 (asynchronously, independent of clk), force out_valid=0, out_data=0, occ=0, xfer_cnt=0.
REQ-027 SHALL drive in_ready=1 during and after reset (all lanes empty); no accept occurs at an edge while rst=1.
REQ-028 SHALL discard all held words when rst asserts mid-operation; first accept after release starts from empty state.

Verification
REQ-029 SHALL pass: reset, then in_valid=1 sel=5 in_data=2'b10 one cycle -> next cycle out_valid=32'h0000_0020, out_data[11:10]=2'b10, occ=1, xfer_cnt=1.
REQ-030 SHALL pass: lane 5 full, in_valid=1 sel=5 in_data=2'b01, out_ack=0 -> in_ready=0, lane 5 keeps 2'b10, xfer_cnt unchanged.
REQ-031 SHALL pass: lane 5 full, out_ack[5]=1 with in_valid=1 sel=5 in_data=2'b01 -> in_ready=1, next cycle out_valid[5]=1, lane 5 = 2'b01, occ unchanged.
REQ-032 SHALL pass: write all 32 lanes sel=0..31 -> occ=32; then out_ack=32'hFFFF_FFFF one cycle -> out_valid=0, occ=0.
REQ-033 SHALL pass: 256 accepts to lanes with continuous ack -> xfer_cnt wraps to 0; out_ack on empty lane 7 -> no change.
REQ-034 SHALL pass: rst asserted between clock edges with occ=3 -> out_valid, occ, xfer_cnt zero immediately, before next edge.
